// File: rtl/uart_pkg.sv
// Shared definitions for the host-bound serial frame sender.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int unsigned frame_len(input int unsigned word_bytes,
                                            input bit          use_checksum);
    return 1 + word_bytes + (use_checksum ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_byte_issuer.sv
// Per-byte handshake with the UART: waits for the line, strobes transmit,
// retries when the UART never starts, and reports acceptance/completion.
module uart_byte_issuer
  import uart_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      last_byte,
  input  logic      uart_is_transmitting,
  output tx_state_t state,
  output logic      uart_transmit,
  output logic      byte_accepted,
  output logic      byte_done
);

  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  tx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    uart_transmit = 1'b0;
    byte_accepted = 1'b0;
    byte_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!uart_is_transmitting) state_d = ISSUE;
      end
      ISSUE: begin
        uart_transmit = 1'b1;
        timer_d       = TW'(START_TIMEOUT);
        state_d       = WAIT_START;
      end
      WAIT_START: begin
        // Retry lands back in ISSUE with the same byte; acceptance is only
        // reported on the edge into WAIT_DONE so retries are never counted.
        if (uart_is_transmitting) begin
          byte_accepted = 1'b1;
          state_d       = WAIT_DONE;
        end else if (timer_q <= TW'(1)) begin
          state_d = ISSUE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          byte_done = 1'b1;
          state_d   = last_byte ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/uart_frame_sender.sv
// Latches one result word and streams it to the UART as
// sync byte, payload bytes LSB-first, optional XOR checksum.
module uart_frame_sender
  import uart_pkg::*;
#(
  parameter int unsigned WORD_BYTES    = 4,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter bit          USE_CHECKSUM  = 1'b1,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    word_valid,
  input  logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_ready,
  output logic                    uart_transmit,
  output logic [7:0]              uart_tx_byte,
  input  logic                    uart_is_transmitting,
  output logic                    busy,
  output logic [15:0]             frames_sent
);

  localparam int unsigned LEN = frame_len(WORD_BYTES, USE_CHECKSUM);
  localparam int unsigned IW  = 5;

  tx_state_t               state;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [IW-1:0]           idx_q;
  logic [7:0]              csum_q;
  logic [15:0]             fs_q;
  logic                    accept;
  logic                    last_byte;
  logic                    is_payload;
  logic                    byte_accepted;
  logic                    byte_done;
  logic [7:0]              cur_byte;

  assign word_ready = (state == IDLE);
  assign accept     = word_valid && word_ready;
  assign last_byte  = (idx_q == IW'(LEN - 1));
  assign is_payload = (idx_q != '0) && (idx_q <= IW'(WORD_BYTES));

  uart_byte_issuer #(
    .START_TIMEOUT(START_TIMEOUT)
  ) u_issuer (
    .clk                  (clk),
    .rst                  (rst),
    .start                (accept),
    .last_byte            (last_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .state                (state),
    .uart_transmit        (uart_transmit),
    .byte_accepted        (byte_accepted),
    .byte_done            (byte_done)
  );

  always_comb begin
    cur_byte = csum_q;
    if (idx_q == '0) begin
      cur_byte = SYNC_BYTE;
    end else begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        if (idx_q == IW'(k + 1)) cur_byte = word_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      csum_q <= '0;
      fs_q   <= '0;
    end else begin
      if (accept) begin
        word_q <= word_data;
        idx_q  <= '0;
        csum_q <= '0;
      end
      if (byte_accepted && is_payload) csum_q <= csum_q ^ cur_byte;
      if (byte_done) begin
        if (last_byte) fs_q  <= fs_q + 16'd1;
        else           idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign uart_tx_byte = (state == IDLE) ? '0 : cur_byte;
  assign busy         = (state != IDLE);
  assign frames_sent  = fs_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Self-checking bench: two senders (with/without checksum) against a UART model.
module tb_uart_frame_sender;
  import uart_pkg::*;

  localparam int unsigned TO = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          lane;
    logic [31:0] word;
    int unsigned bl;
    int          ign;
    int unsigned hold_n;
    int unsigned exp_len;
    logic [7:0]  exp_last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wv[2];
  logic [31:0] wd[2];
  logic        wr[2];
  logic        ts[2];
  logic [7:0]  txb[2];
  logic        ist[2] = '{1'b0, 1'b0};
  logic        bsy[2];
  logic [15:0] fs[2];

  uart_frame_sender #(.WORD_BYTES(4), .SYNC_BYTE(8'hA5), .USE_CHECKSUM(1'b1), .START_TIMEOUT(TO)) u_ck (
    .clk(clk), .rst(rst), .word_valid(wv[0]), .word_data(wd[0]), .word_ready(wr[0]),
    .uart_transmit(ts[0]), .uart_tx_byte(txb[0]), .uart_is_transmitting(ist[0]),
    .busy(bsy[0]), .frames_sent(fs[0]));

  uart_frame_sender #(.WORD_BYTES(4), .SYNC_BYTE(8'hA5), .USE_CHECKSUM(1'b0), .START_TIMEOUT(TO)) u_nck (
    .clk(clk), .rst(rst), .word_valid(wv[1]), .word_data(wd[1]), .word_ready(wr[1]),
    .uart_transmit(ts[1]), .uart_tx_byte(txb[1]), .uart_is_transmitting(ist[1]),
    .busy(bsy[1]), .frames_sent(fs[1]));

  // UART model: busy for blen cycles after an accepted strobe, can be held
  // busy externally, and can ignore one chosen strobe.
  logic        hold[2]      = '{1'b0, 1'b0};
  logic        hold_prev[2] = '{1'b0, 1'b0};
  logic        clr[2]       = '{1'b0, 1'b0};
  int unsigned blen[2]      = '{3, 3};
  int          ignore_at[2] = '{-1, -1};
  int unsigned cyc          = 0;
  int unsigned busy_cnt[2]  = '{0, 0};
  int unsigned nstr[2]      = '{0, 0};
  int unsigned viol[2]      = '{0, 0};
  int unsigned acc_cyc[2]   = '{0, 0};
  int unsigned fall_cyc[2]  = '{0, 0};
  logic [7:0]  st_byte[2][64];
  int unsigned st_cyc[2][64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < 2; l++) begin
      hold_prev[l] <= hold[l];
      if (hold_prev[l] && !hold[l]) fall_cyc[l] <= cyc;
      if (wv[l] && wr[l]) acc_cyc[l] <= cyc;
      if (ts[l] && ist[l]) viol[l] <= viol[l] + 1;
      if (clr[l]) nstr[l] <= 0;
      else if (ts[l] && nstr[l] < 64) begin
        st_byte[l][nstr[l]] <= txb[l];
        st_cyc[l][nstr[l]]  <= cyc;
        nstr[l]             <= nstr[l] + 1;
      end
      if (ts[l] && !ist[l] && int'(nstr[l]) != ignore_at[l]) begin
        busy_cnt[l] <= blen[l];
        ist[l]      <= 1'b1;
      end else if (busy_cnt[l] > 1) begin
        busy_cnt[l] <= busy_cnt[l] - 1;
        ist[l]      <= 1'b1;
      end else begin
        busy_cnt[l] <= 0;
        ist[l]      <= hold[l];
      end
    end
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bq_t ref_frame(input logic [31:0] w, input bit ck);
    bq_t q;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = 8'((w >> (8 * i)) & 32'hFF);
      q.push_back(b);
      x = x ^ b;
    end
    if (ck) q.push_back(x);
    return q;
  endfunction

  task automatic run_frame(input vec_t v, input string nm);
    bq_t exp;
    int unsigned fs0;
    int unsigned gap_exp;
    int unsigned gap;
    int unsigned n;
    bit done;
    int l;
    l   = v.lane;
    exp = ref_frame(v.word, l == 0);
    if (v.ign >= 0) exp.insert(v.ign, exp[v.ign]);
    @(negedge clk);
    blen[l] = v.bl; ignore_at[l] = v.ign; clr[l] = 1'b1; hold[l] = (v.hold_n != 0);
    @(negedge clk);
    clr[l] = 1'b0;
    fs0 = fs[l];
    chk({nm, " ready_before"}, 32'(wr[l]), 1);
    wv[l] = 1'b1; wd[l] = v.word;
    @(negedge clk);
    wv[l] = 1'b0; wd[l] = $urandom;
    chk({nm, " ready_low"}, 32'(wr[l]), 0);
    if (v.hold_n != 0) begin
      repeat (v.hold_n) @(negedge clk);
      chk({nm, " no_strobe_while_held"}, nstr[l], 0);
      hold[l] = 1'b0;
    end
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (!bsy[l]) done = 1'b1;
    end
    chk({nm, " frame_done"}, 32'(done), 1);
    chk({nm, " ready_after"}, 32'(wr[l]), 1);
    chk({nm, " strobe_count"}, nstr[l], exp.size());
    chk({nm, " table_len"}, nstr[l], v.exp_len);
    n = (nstr[l] < exp.size()) ? nstr[l] : exp.size();
    for (int unsigned k = 0; k < n; k++)
      chk($sformatf("%s byte%0d", nm, k), st_byte[l][k], exp[k]);
    if (n > 0) chk({nm, " table_last"}, st_byte[l][n-1], v.exp_last);
    chk({nm, " frames_sent"}, fs[l], 32'(16'(fs0 + 1)));
    if (n > 0) begin
      if (v.hold_n == 0) chk({nm, " first_latency"}, st_cyc[l][0] - acc_cyc[l], 2);
      else               chk({nm, " latency_after_fall"}, st_cyc[l][0] - fall_cyc[l], 2);
    end
    for (int unsigned k = 1; k < n; k++) begin
      gap = st_cyc[l][k] - st_cyc[l][k-1];
      if (v.ign >= 0 && int'(k) == v.ign + 1) begin
        chk($sformatf("%s retry_gap%0d=%0d", nm, k, gap), 32'(gap >= TO && gap <= TO + 1), 1);
      end else begin
        gap_exp = v.bl + 2;
        chk($sformatf("%s gap%0d", nm, k), gap, gap_exp);
      end
    end
  endtask

  vec_t vt[5];
  vec_t rv;
  bq_t  rf;
  bit   done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 32'h12345678, 3, -1, 0,  6, 8'h08};
    vt[1] = '{1, 32'hDEADBEEF, 2, -1, 0,  5, 8'hDE};
    vt[2] = '{0, 32'h12345678, 4,  2, 0,  7, 8'h08};
    vt[3] = '{0, 32'hCAFEF00D, 2, -1, 50, 6, 8'hC9};
    vt[4] = '{1, 32'h00000000, 1, -1, 0,  5, 8'h00};
    wv[0] = 1'b0; wv[1] = 1'b0; wd[0] = '0; wd[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst ready%0d", l), 32'(wr[l]), 1);
      chk($sformatf("rst transmit%0d", l), 32'(ts[l]), 0);
      chk($sformatf("rst tx_byte%0d", l), txb[l], 0);
      chk($sformatf("rst busy%0d", l), 32'(bsy[l]), 0);
      chk($sformatf("rst frames%0d", l), fs[l], 0);
    end
    rst = 1'b0;

    // Reset during payload byte 3, then a fresh frame.
    @(negedge clk);
    blen[0] = 3; ignore_at[0] = -1; clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0; wv[0] = 1'b1; wd[0] = 32'h12345678;
    @(negedge clk);
    wv[0] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (nstr[0] >= 4) done = 1'b1;
      else @(negedge clk);
    end
    chk("midrst reached_byte3", 32'(done), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(bsy[0]), 0);
    chk("midrst ready", 32'(wr[0]), 1);
    chk("midrst transmit", 32'(ts[0]), 0);
    chk("midrst frames", fs[0], 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst no_more_bytes", nstr[0], 4);
    run_frame(vt[0], "after_rst");

    for (int i = 0; i < 5; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv.lane     = int'($urandom_range(0, 1));
      rv.word     = $urandom;
      rv.bl       = $urandom_range(1, 5);
      rv.hold_n   = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 12) : 0;
      rf          = ref_frame(rv.word, rv.lane == 0);
      rv.ign      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rf.size() - 1)) : -1;
      rv.exp_len  = rf.size() + ((rv.ign >= 0) ? 1 : 0);
      rv.exp_last = rf[rf.size() - 1];
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    // Counter wrap.
    @(negedge clk);
    force u_ck.fs_q = 16'hFFFF;
    @(negedge clk);
    release u_ck.fs_q;
    @(negedge clk);
    chk("wrap preload", fs[0], 32'hFFFF);
    run_frame(vt[0], "wrap");
    chk("wrap zero", fs[0], 0);

    chk("no_strobe_while_busy0", viol[0], 0);
    chk("no_strobe_while_busy1", viol[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_sender.md
Name: uart_frame_sender

Overview:
Host-bound side of the miner's serial link. Accepts one result word (e.g. a found nonce) from the core via a valid/ready handshake and serializes it into a framed byte stream. It drives the byte-level transmit interface of the existing UART block (transmit / tx_byte / is_transmitting). Frame = sync byte, payload bytes LSB-first, optional XOR checksum byte.

Parameters:
WORD_BYTES, 4, payload length in bytes (1..16); word_data width = 8*WORD_BYTES
SYNC_BYTE, 8'hA5, first byte of every frame
USE_CHECKSUM, 1, 1 = append XOR-of-payload byte; 0 = no checksum byte
START_TIMEOUT, 8, cycles to wait for uart_is_transmitting to rise before re-issuing the byte (>=2)

Ports:
clk  input  1  master clock, same domain as the UART
rst  input  1  synchronous reset, active-high
word_valid  input  1  core presents a word
word_data  input  8*WORD_BYTES  word to send
word_ready  output  1  high when a word can be accepted
uart_transmit  output  1  one-cycle strobe to the UART transmit input
uart_tx_byte  output  8  byte to the UART; stable while in issue/wait states
uart_is_transmitting  input  1  UART transmitter busy
busy  output  1  frame in progress (not IDLE)
frames_sent  output  16  count of completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values:
  - state = IDLE; word_ready = 1; uart_transmit = 0; uart_tx_byte = 0; busy = 0; frames_sent = 0; checksum = 0; byte index = 0.
  - Reset mid-frame discards the word immediately. The UART may finish its current byte; no further bytes are issued.
- Frame length: L = 1 + WORD_BYTES + USE_CHECKSUM. Byte k = SYNC_BYTE for k=0, word_data[8(k-1)+:8] for 1..WORD_BYTES, checksum for the last byte when enabled.
- Checksum: XOR of payload bytes only, seed 8'h00. Accumulated as each payload byte is issued.
- word_ready = (state==IDLE). On word_valid && word_ready the word is latched, index = 0, checksum = 0, state -> WAIT_IDLE. word_data is don't-care afterwards.
- States:
  - IDLE: wait for the accept handshake.
  - WAIT_IDLE: stay while uart_is_transmitting=1 (link shared or previous byte draining). When 0 -> ISSUE.
  - ISSUE: uart_transmit=1 for exactly one cycle, uart_tx_byte = byte[index]. Load the timeout counter = START_TIMEOUT. -> WAIT_START.
  - WAIT_START: if uart_is_transmitting=1 -> WAIT_DONE. Else decrement the timeout; at 0 -> ISSUE (same index, checksum not re-accumulated).
  - WAIT_DONE: when uart_is_transmitting=0: if index==L-1 then frames_sent++ and -> IDLE; else index++ and -> ISSUE.
- Latency: the accept cycle is cycle 0. The first uart_transmit is at cycle 2 if the UART is idle. Each subsequent byte's strobe comes 1 cycle after is_transmitting falls.
- uart_transmit is never high outside ISSUE. It is never asserted while uart_is_transmitting=1.
- word_valid held high in IDLE is accepted immediately. Back-to-back frames are permitted; word_ready returns to 1 the cycle after the last WAIT_DONE exit.
- Checksum accumulation occurs on the transition out of WAIT_START into WAIT_DONE, so retries never double-count.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE, WAIT_IDLE, ISSUE, WAIT_START, WAIT_DONE);
  - the default SYNC_BYTE;
  - the frame-length function of WORD_BYTES/USE_CHECKSUM.
- One natural sub-module: uart_byte_issuer. It owns the ISSUE/WAIT_START/WAIT_DONE handshake and timeout, and reports byte_done. The top owns the framing, index, checksum and the counter.

Test Plan:
- Word 32'h12345678, UART model idle, USE_CHECKSUM=1 -> tx bytes A5,78,56,34,12,08; frames_sent 0->1; word_ready low until the final byte completes.
- USE_CHECKSUM=0, word 32'hDEADBEEF -> exactly 4'd5 strobes: A5,EF,BE,AD,DE; no sixth byte.
- uart_is_transmitting held high 50 cycles at accept -> no uart_transmit until it falls; first strobe 1 cycle after the fall.
- UART model ignores the first strobe of byte 2 -> re-issue after START_TIMEOUT=8 cycles with the same byte; checksum still correct (08 for 32'h12345678).
- rst asserted during payload byte 3 -> the next cycle has state IDLE, word_ready=1, uart_transmit=0, frames_sent unchanged; a new word then sends a full fresh frame from A5.
- Preload frames_sent=16'hFFFF by sending 65535 frames (or force) -> the next completed frame wraps it to 16'h0000.
